sequenciador_display: RTL

SEQUENCIADOR_DISPLAY -- requirements
Module: sequenciador_display

---
 rtl/sequenciador_pkg.sv | 38 +++
 rtl/gerador_tick.sv | 29 ++
 rtl/sequenciador_display.sv | 101 ++++++++++
 3 files changed

// File: rtl/sequenciador_pkg.sv
// Shared types for the sequence display: command codes, FSM states
// and the active-low 7-segment encoder.
package sequenciador_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD  = 2'b00,
        CMD_FWD   = 2'b01,
        CMD_BACK  = 2'b10,
        CMD_BLANK = 2'b11
    } cmd_t;

    typedef enum logic {
        RUN   = 1'b0,
        BLANK = 1'b1
    } estado_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Bit 6 = segment a ... bit 0 = segment g, active-low.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/gerador_tick.sv
// Free-running divider producing a one-cycle step strobe every
// DIV_MAX clock cycles.
module gerador_tick #(
    parameter int DIV_MAX = 50000000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV_MAX - 1);

    logic [CW-1:0] r_cont;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cont <= '0;
        end else if (r_cont == LAST) begin
            r_cont <= '0;
        end else begin
            r_cont <= r_cont + 1'b1;
        end
    end

    // Gated by reset so a coincident tick is suppressed (matters for DIV_MAX=1).
    assign tick = ~reset & (r_cont == LAST);

endmodule

// File: rtl/sequenciador_display.sv
// Steps through a ROM of digits on each tick and shows a sliding
// window of DIGITS entries on 7-segment displays.
module sequenciador_display
    import sequenciador_pkg::*;
#(
    parameter int                   DIGITS  = 2,
    parameter int                   SEQ_LEN = 9,
    parameter logic [4*SEQ_LEN-1:0] SEQ_ROM = 36'h253750813,
    parameter int                   DIV_MAX = 50000000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 entradas,
    input  logic                       modo,
    output logic                       tick,
    output logic [$clog2(SEQ_LEN)-1:0] indice,
    output logic                       apagado,
    output logic [7*DIGITS-1:0]        HEX,
    output logic [6:0]                 previa
);

    localparam int IW = $clog2(SEQ_LEN);
    localparam logic [IW-1:0] ULT = IW'(SEQ_LEN - 1);

    function automatic logic [7*DIGITS-1:0] mostra(
        input estado_t       e,
        input logic [IW-1:0] idx
    );
        logic [7*DIGITS-1:0] h;
        int ent;
        h = '1;
        if (e == RUN) begin
            for (int k = 0; k < DIGITS; k++) begin
                ent = int'(idx) + k;
                if (ent >= SEQ_LEN) ent = ent - SEQ_LEN;
                h[7*k +: 7] = seg7(SEQ_ROM[4*ent +: 4]);
            end
        end
        return h;
    endfunction

    logic                w_tick;
    cmd_t                w_cmd;
    estado_t             w_prox_estado;
    logic [IW-1:0]       w_prox_indice;
    logic [7*DIGITS-1:0] w_prox_hex;

    estado_t             r_estado;
    logic [IW-1:0]       r_indice;
    logic [7*DIGITS-1:0] r_hex;

    gerador_tick #(
        .DIV_MAX(DIV_MAX)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .tick (w_tick)
    );

    always_comb begin
        w_prox_estado = r_estado;
        w_prox_indice = r_indice;
        w_cmd = (cmd_t'(entradas) == CMD_HOLD && modo) ? CMD_FWD
                                                       : cmd_t'(entradas);
        if (r_estado == RUN) begin
            unique case (w_cmd)
                CMD_HOLD:  w_prox_indice = r_indice;
                CMD_FWD:   w_prox_indice = (r_indice == ULT) ? '0
                                                              : r_indice + 1'b1;
                CMD_BACK:  w_prox_indice = (r_indice == '0) ? ULT
                                                             : r_indice - 1'b1;
                CMD_BLANK: w_prox_estado = BLANK;
            endcase
        end else if (entradas == CMD_FWD || entradas == CMD_BACK) begin
            // Leaving BLANK ignores modo and restarts the sequence.
            w_prox_estado = RUN;
            w_prox_indice = '0;
        end
    end

    assign w_prox_hex = mostra(w_prox_estado, w_prox_indice);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= RUN;
            r_indice <= '0;
            r_hex    <= mostra(RUN, '0);
        end else if (w_tick) begin
            r_estado <= w_prox_estado;
            r_indice <= w_prox_indice;
            r_hex    <= w_prox_hex;
        end
    end

    assign tick    = w_tick;
    assign indice  = r_indice;
    assign apagado = (r_estado == BLANK);
    assign HEX     = r_hex;
    assign previa  = w_prox_hex[6:0];

endmodule
